// File: rtl/down_counter_timer.sv
// Loadable down-counter timer: counts a programmed value down to zero, pulses tc on
// expiry, then either parks in DONE or reloads the stored value for periodic operation.
module down_counter_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = WIDTH'(0);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_reload;
  logic             r_tc;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0] w_reload_nxt;
  logic             w_tc_nxt;

  // State, counter, reload value and tc pulse registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_count  <= ZERO;
      r_reload <= ZERO;
      r_tc     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_reload <= w_reload_nxt;
      r_tc     <= w_tc_nxt;
    end
  end

  // Next-state logic; load overrides everything, including an expiring count
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_reload_nxt = r_reload;
    w_tc_nxt     = 1'b0;
    if (load) begin
      w_count_nxt  = load_value;
      w_reload_nxt = load_value;
      w_state_nxt  = (load_value != ZERO) ? S_RUN : S_IDLE;
    end else begin
      case (r_state)
        S_RUN: begin
          if (enable) begin
            if (r_count == ONE) begin
              w_tc_nxt = 1'b1;
              if (auto_reload) begin
                w_count_nxt = r_reload;
              end else begin
                w_count_nxt = ZERO;
                w_state_nxt = S_DONE;
              end
            end else if (r_count > ONE) begin
              w_count_nxt = r_count - ONE;
            end else begin
              // count==0 in RUN cannot be reached; hold rather than wrap
              w_count_nxt = r_count;
            end
          end else begin
            w_count_nxt = r_count;
          end
        end
        S_DONE: begin
          w_count_nxt = ZERO;
        end
        S_IDLE: begin
          w_count_nxt = r_count;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_count_nxt = ZERO;
        end
      endcase
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign busy  = (r_state == S_RUN);
  assign done  = (r_state == S_DONE);

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: directed scenarios from the timer's
// behaviour plus randomized traffic checked against an arithmetic reference model.
module tb_down_counter_timer;

  logic       clk;
  logic       reset;
  logic       load;
  logic [3:0] load_value;
  logic       enable;
  logic       auto_reload;
  logic [3:0] count;
  logic       busy;
  logic       tc;
  logic       done;

  int total = 0;
  int bad   = 0;

  // reference model: remaining count, stored period, running / finished flags
  int m_cnt  = 0;
  int m_rel  = 0;
  bit m_run  = 0;
  bit m_done = 0;
  bit m_tc   = 0;

  down_counter_timer #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .enable(enable), .auto_reload(auto_reload),
    .count(count), .busy(busy), .tc(tc), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    m_cnt = 0; m_rel = 0; m_run = 0; m_done = 0; m_tc = 0;
  endtask

  // advance one clock edge, update the model from the inputs seen at that edge
  task automatic tick();
    @(posedge clk);
    m_tc = 0;
    if (load) begin
      m_cnt  = int'(load_value);
      m_rel  = int'(load_value);
      m_run  = (load_value != 4'd0);
      m_done = 0;
    end else if (m_run && enable) begin
      if (m_cnt == 1) begin
        m_tc = 1;
        if (auto_reload) m_cnt = m_rel;
        else begin
          m_cnt = 0; m_run = 0; m_done = 1;
        end
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; load_value = 4'd0; enable = 1'b0; auto_reload = 1'b0;
    tick(); tick();
    total++;
    if ({count, busy, tc, done} !== 7'b0000_000) begin
      bad++; $display("FAIL reset_hold got cnt=%0d b=%b t=%b d=%b exp all 0", count, busy, tc, done);
    end
    reset = 1'b0; model_clear();
    load = 1'b1; load_value = 4'd6; tick(); load = 1'b0;
    total++;
    if ({count, busy} !== {4'd6, 1'b1}) begin
      bad++; $display("FAIL reset_preload got cnt=%0d b=%b exp cnt=6 b=1", count, busy);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({count, busy, tc, done} !== 7'b0000_000) begin
      bad++; $display("FAIL reset_async got cnt=%0d b=%b t=%b d=%b exp all 0", count, busy, tc, done);
    end
    reset = 1'b0; model_clear();
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({count, busy, tc, done} !== 7'b0000_000) begin
        bad++; $display("FAIL reset_idle[%0d] got cnt=%0d b=%b t=%b d=%b exp all 0", i, count, busy, tc, done);
      end
    end
  endtask

  task automatic test_oneshot();
    int exp_c[5] = '{4, 3, 2, 1, 0};
    load = 1'b1; load_value = 4'd5; enable = 1'b1; auto_reload = 1'b0;
    tick(); load = 1'b0;
    total++;
    if ({count, busy, tc, done} !== {4'd5, 3'b100}) begin
      bad++; $display("FAIL oneshot_load got cnt=%0d b=%b t=%b d=%b exp cnt=5 b=1 t=0 d=0", count, busy, tc, done);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({count, busy, tc, done} !== {4'(exp_c[i]), (i < 4), (i == 4), (i == 4)}) begin
        bad++; $display("FAIL oneshot[%0d] got cnt=%0d b=%b t=%b d=%b exp cnt=%0d", i, count, busy, tc, done, exp_c[i]);
      end
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if ({count, busy, tc, done} !== 7'b0000_001) begin
        bad++; $display("FAIL oneshot_done[%0d] got cnt=%0d b=%b t=%b d=%b exp cnt=0 d=1", i, count, busy, tc, done);
      end
    end
  endtask

  task automatic test_periodic();
    int exp_c[9] = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
    int pulses = 0;
    load = 1'b1; load_value = 4'd3; enable = 1'b1; auto_reload = 1'b1;
    tick(); load = 1'b0;
    total++;
    if ({count, busy} !== {4'd3, 1'b1}) begin
      bad++; $display("FAIL periodic_load got cnt=%0d b=%b exp cnt=3 b=1", count, busy);
    end
    for (int i = 0; i < 9; i++) begin
      tick();
      pulses += int'(tc);
      total++;
      if ({count, busy, tc, done} !== {4'(exp_c[i]), 1'b1, (exp_c[i] == 3), 1'b0}) begin
        bad++; $display("FAIL periodic[%0d] got cnt=%0d b=%b t=%b d=%b exp cnt=%0d", i, count, busy, tc, done, exp_c[i]);
      end
    end
    total++;
    if (pulses !== 3) begin
      bad++; $display("FAIL periodic_pulses got %0d exp 3", pulses);
    end
  endtask

  task automatic test_stall();
    bit en_pat[6] = '{1, 0, 0, 1, 1, 1};
    int exp_c[6]  = '{3, 3, 3, 2, 1, 0};
    load = 1'b1; load_value = 4'd4; enable = 1'b1; auto_reload = 1'b0;
    tick(); load = 1'b0;
    total++;
    if (count !== 4'd4) begin
      bad++; $display("FAIL stall_load got cnt=%0d exp 4", count);
    end
    for (int i = 0; i < 6; i++) begin
      enable = en_pat[i];
      tick();
      total++;
      if ({count, tc, done} !== {4'(exp_c[i]), (i == 5), (i == 5)}) begin
        bad++; $display("FAIL stall[%0d] got cnt=%0d t=%b d=%b exp cnt=%0d", i, count, tc, done, exp_c[i]);
      end
    end
  endtask

  task automatic test_collision();
    load = 1'b1; load_value = 4'd15; enable = 1'b1; auto_reload = 1'b0;
    tick(); load = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    total++;
    if ({count, busy, tc} !== {4'd1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL coll_pre got cnt=%0d b=%b t=%b exp cnt=1 b=1 t=0", count, busy, tc);
    end
    load = 1'b1; load_value = 4'd7;
    tick();
    total++;
    if ({count, busy, tc, done} !== {4'd7, 3'b100}) begin
      bad++; $display("FAIL coll_load got cnt=%0d b=%b t=%b d=%b exp cnt=7 b=1 t=0 d=0", count, busy, tc, done);
    end
    load_value = 4'd0;
    tick(); load = 1'b0;
    total++;
    if ({count, busy, tc, done} !== 7'b0000_000) begin
      bad++; $display("FAIL coll_zero got cnt=%0d b=%b t=%b d=%b exp all 0", count, busy, tc, done);
    end
  endtask

  task automatic test_reset_midrun();
    load = 1'b1; load_value = 4'd9; enable = 1'b1; auto_reload = 1'b0;
    tick(); load = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (count !== 4'd6) begin
      bad++; $display("FAIL midrun_pre got cnt=%0d exp 6", count);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({count, busy, tc, done} !== 7'b0000_000) begin
      bad++; $display("FAIL midrun_async got cnt=%0d b=%b t=%b d=%b exp all 0", count, busy, tc, done);
    end
    reset = 1'b0; model_clear();
    load = 1'b1; load_value = 4'd2;
    tick(); load = 1'b0;
    tick();
    tick();
    total++;
    if ({count, busy, tc, done} !== 7'b0000_011) begin
      bad++; $display("FAIL midrun_reload got cnt=%0d b=%b t=%b d=%b exp cnt=0 t=1 d=1", count, busy, tc, done);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      load        = ($urandom_range(0, 9) == 0);
      load_value  = 4'($urandom_range(0, 15));
      enable      = ($urandom_range(0, 3) != 0);
      auto_reload = $urandom_range(0, 1) == 1;
      tick();
      total++;
      if ({count, busy, tc, done} !== {4'(m_cnt), m_run, m_tc, m_done}) begin
        bad++;
        $display("FAIL random[%0d] got cnt=%0d b=%b t=%b d=%b exp cnt=%0d b=%b t=%b d=%b",
                 i, count, busy, tc, done, m_cnt, m_run, m_tc, m_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_stall();
    test_collision();
    test_reset_midrun();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
